// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI mode-0 master sequencer.
package spi_pkg;

   localparam int unsigned SPI_SIZE    = 8;
   localparam int unsigned SPI_CLK_DIV = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_LEAD  = 3'd2;
   localparam logic [2:0] ST_XFER  = 3'd3;
   localparam logic [2:0] ST_TRAIL = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StLoad  = ST_LOAD,
      StLead  = ST_LEAD,
      StXfer  = ST_XFER,
      StTrail = ST_TRAIL,
      StDone  = ST_DONE
   } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: Sclk toggles every CLK_DIV cycles while run_i is high,
// and sits at 0 with a cleared divider otherwise.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic sclk_o,
   output logic rise_stb_o,
   output logic fall_stb_o
);

   localparam int unsigned DivW = $clog2(CLK_DIV);

   logic [DivW-1:0] div_q, div_d;
   logic            sclk_q, sclk_d;
   logic            tc;

   assign tc = run_i && (div_q == DivW'(CLK_DIV - 1));

   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (!run_i) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (tc) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d  = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   // Strobes mark the cycle whose closing edge moves Sclk.
   assign rise_stb_o = tc && !sclk_q;
   assign fall_stb_o = tc && sclk_q;
   assign sclk_o     = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: strobes the TX shift register, drives Sclk/Cs_n
// and collects Miso into RxData, MSB first.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned SIZE    = SPI_SIZE,
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            miso_i,
   output logic            load_o,
   output logic            en_o,
   output logic            sclk_o,
   output logic            cs_n_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [SIZE-1:0] rx_data_o
);

   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam int unsigned CntW = $clog2(SIZE + 1);

   spi_state_e      state_q, state_d;
   logic [DivW-1:0] wait_q, wait_d;
   logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [SIZE-1:0] rx_q, rx_d;
   logic [SIZE-1:0] rx_data_q, rx_data_d;
   logic            rise_stb, fall_stb;
   logic            wait_tc, last_fall;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .run_i      (state_q == StXfer),
      .sclk_o     (sclk_o),
      .rise_stb_o (rise_stb),
      .fall_stb_o (fall_stb)
   );

   assign wait_tc   = (wait_q == DivW'(CLK_DIV - 1));
   assign last_fall = fall_stb && (bit_cnt_q == CntW'(SIZE - 1));

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = StLoad;
         end
         StLoad: begin
            bit_cnt_d = '0;
            state_d   = StLead;
         end
         StLead: begin
            wait_d = wait_q + 1'b1;
            if (wait_tc) begin
               wait_d  = '0;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (rise_stb) rx_d = {rx_q[SIZE-2:0], miso_i};
            if (fall_stb) bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_fall) state_d = StTrail;
         end
         StTrail: begin
            wait_d = wait_q + 1'b1;
            // Capture on entry to DONE so RxData is already valid during Done.
            if (wait_tc) begin
               wait_d    = '0;
               rx_data_d = rx_q;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
      end
   end

   // The final falling toggle carries no En: the shifter has nothing left to present.
   assign en_o      = fall_stb && (bit_cnt_q < CntW'(SIZE - 1));
   assign load_o    = (state_q == StLoad);
   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);
   assign cs_n_o    = !((state_q == StLead) || (state_q == StXfer) || (state_q == StTrail));
   assign rx_data_o = rx_data_q;

endmodule
